// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32I datapath: register enables, mux selects,
// ALU op, register-file write and a memory handshake with a timeout trap.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_zero,
  input  logic       i_mem_rdy,
  output logic       o_pc_en,
  output logic       o_ir_en,
  output logic       o_ab_en,
  output logic       o_aluout_en,
  output logic       o_mdr_en,
  output logic       o_rf_we,
  output logic       o_mem_rd,
  output logic       o_mem_wr,
  output logic       o_addr_sel,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_wb_sel,
  output logic [1:0] o_pc_src,
  output logic       o_err,
  output logic [3:0] o_state
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JAL      = 4'd9,
    S_LUI      = 4'd10,
    S_WB_ALU   = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic               w_mem_state;
  logic               w_timeout;
  logic               w_taken;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_timeout   = w_mem_state && !i_mem_rdy && (r_wait_cnt == CNT_W'(MEM_TIMEOUT));
  assign w_taken     = ((i_funct3 == 3'b000) && i_zero) || ((i_funct3 == 3'b001) && !i_zero);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Memory wait counter; restarts whenever the state changes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                        r_wait_cnt <= '0;
    else if (w_next != r_state)       r_wait_cnt <= '0;
    else if (w_mem_state && !i_mem_rdy) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (i_mem_rdy)      w_next = S_DECODE;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_DECODE: begin
        case (i_opcode)
          OP_R:               w_next = S_EXEC_R;
          OP_I:               w_next = S_EXEC_I;
          OP_LOAD, OP_STORE:  w_next = S_MEM_ADDR;
          OP_BRANCH:          w_next = S_BRANCH;
          OP_JAL:             w_next = S_JAL;
          OP_LUI:             w_next = S_LUI;
          default:            w_next = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I: w_next = S_WB_ALU;
      S_MEM_ADDR:         w_next = (i_opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (i_mem_rdy)      w_next = S_MEM_WB;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_MEM_WR: begin
        if (i_mem_rdy)      w_next = S_FETCH;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_MEM_WB, S_BRANCH, S_JAL, S_LUI, S_WB_ALU: w_next = S_FETCH;
      S_TRAP:             w_next = S_TRAP;
      default:            w_next = S_TRAP;
    endcase
  end

  // Output decode; everything held low while reset is asserted
  always_comb begin
    o_pc_en     = 1'b0;
    o_ir_en     = 1'b0;
    o_ab_en     = 1'b0;
    o_aluout_en = 1'b0;
    o_mdr_en    = 1'b0;
    o_rf_we     = 1'b0;
    o_mem_rd    = 1'b0;
    o_mem_wr    = 1'b0;
    o_addr_sel  = 1'b0;
    o_alu_src_a = 1'b0;
    o_alu_src_b = 2'd0;
    o_alu_op    = 2'd0;
    o_wb_sel    = 2'd0;
    o_pc_src    = 2'd0;
    o_err       = 1'b0;
    o_state     = 4'd0;
    if (!i_rst) begin
      o_state = r_state;
      case (r_state)
        S_FETCH: begin
          o_mem_rd    = 1'b1;
          o_alu_src_b = 2'd1;
          o_ir_en     = i_mem_rdy;
          o_pc_en     = i_mem_rdy;
        end
        S_DECODE: o_ab_en = 1'b1;
        S_EXEC_R: begin
          o_alu_src_a = 1'b1;
          o_alu_op    = 2'd2;
          o_aluout_en = 1'b1;
        end
        S_EXEC_I: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = 2'd2;
          o_alu_op    = 2'd2;
          o_aluout_en = 1'b1;
        end
        S_MEM_ADDR: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = 2'd2;
          o_aluout_en = 1'b1;
        end
        S_MEM_RD: begin
          o_mem_rd   = 1'b1;
          o_addr_sel = 1'b1;
          o_mdr_en   = i_mem_rdy;
        end
        S_MEM_WB: begin
          o_rf_we  = 1'b1;
          o_wb_sel = 2'd1;
        end
        S_MEM_WR: begin
          o_mem_wr   = 1'b1;
          o_addr_sel = 1'b1;
        end
        S_BRANCH: begin
          o_alu_src_a = 1'b1;
          o_alu_op    = 2'd1;
          o_pc_src    = 2'd1;
          o_pc_en     = w_taken;
        end
        S_JAL: begin
          o_rf_we  = 1'b1;
          o_wb_sel = 2'd2;
          o_pc_en  = 1'b1;
          o_pc_src = 2'd2;
        end
        S_LUI: begin
          o_rf_we  = 1'b1;
          o_wb_sel = 2'd3;
        end
        S_WB_ALU: o_rf_we = 1'b1;
        S_TRAP:   o_err   = 1'b1;
        default:  o_err   = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench: instruction-level model expands each instruction into its
// expected per-cycle control outputs, which are checked against the controller.
module tb_multicycle_ctrl;

  localparam int unsigned MEM_TIMEOUT = 15;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  typedef struct packed {
    logic       pc_en, ir_en, ab_en, aluout_en, mdr_en, rf_we;
    logic       mem_rd, mem_wr, addr_sel, alu_src_a;
    logic [1:0] alu_src_b, alu_op, wb_sel, pc_src;
    logic       err;
  } out_t;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic       zero;
    logic       rdy;
    out_t       exp;
  } vec_t;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [6:0] i_opcode = '0;
  logic [2:0] i_funct3 = '0;
  logic       i_zero = 1'b0;
  logic       i_mem_rdy = 1'b0;
  logic       o_pc_en, o_ir_en, o_ab_en, o_aluout_en, o_mdr_en, o_rf_we;
  logic       o_mem_rd, o_mem_wr, o_addr_sel, o_alu_src_a, o_err;
  logic [1:0] o_alu_src_b, o_alu_op, o_wb_sel, o_pc_src;
  logic [3:0] o_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_rd_alu = 0;
  int n_mdr = 0;
  int n_rfwe = 0;

  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_zero;
  vec_t       q[$];

  multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_funct3(i_funct3),
    .i_zero(i_zero), .i_mem_rdy(i_mem_rdy),
    .o_pc_en(o_pc_en), .o_ir_en(o_ir_en), .o_ab_en(o_ab_en),
    .o_aluout_en(o_aluout_en), .o_mdr_en(o_mdr_en), .o_rf_we(o_rf_we),
    .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_addr_sel(o_addr_sel),
    .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b), .o_alu_op(o_alu_op),
    .o_wb_sel(o_wb_sel), .o_pc_src(o_pc_src), .o_err(o_err), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  function automatic out_t cur();
    out_t o;
    o.pc_en = o_pc_en;   o.ir_en = o_ir_en;   o.ab_en = o_ab_en;
    o.aluout_en = o_aluout_en; o.mdr_en = o_mdr_en; o.rf_we = o_rf_we;
    o.mem_rd = o_mem_rd; o.mem_wr = o_mem_wr; o.addr_sel = o_addr_sel;
    o.alu_src_a = o_alu_src_a; o.alu_src_b = o_alu_src_b; o.alu_op = o_alu_op;
    o.wb_sel = o_wb_sel; o.pc_src = o_pc_src; o.err = o_err;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(input out_t e, input logic rdy);
    vec_t v;
    v.op = cur_op; v.f3 = cur_f3; v.zero = cur_zero; v.rdy = rdy; v.exp = e;
    q.push_back(v);
  endtask

  // A memory transfer: 'waits' not-ready cycles then a ready cycle, or a trap on timeout
  task automatic mem_phase(input out_t wait_o, input out_t done_o, input int waits,
                           output bit trapped);
    int n;
    n = (waits > int'(MEM_TIMEOUT)) ? int'(MEM_TIMEOUT) + 1 : waits;
    for (int i = 0; i < n; i++) push(wait_o, 1'b0);
    trapped = (waits > int'(MEM_TIMEOUT));
    if (!trapped) push(done_o, 1'b1);
  endtask

  task automatic trap_cycles(input int n);
    out_t o;
    o = '0; o.err = 1'b1;
    for (int i = 0; i < n; i++) push(o, (i % 4) == 1);
  endtask

  // Expand one instruction into its expected cycles; non-memory cycles see MEM_RDY=1
  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic zero,
                       input int fwait, input int mwait);
    out_t w, d;
    bit tr;
    cur_op = op; cur_f3 = f3; cur_zero = zero;
    w = '0; w.mem_rd = 1'b1; w.alu_src_b = 2'd1;
    d = w;  d.ir_en = 1'b1;  d.pc_en = 1'b1;
    mem_phase(w, d, fwait, tr);
    if (tr) return;
    w = '0; w.ab_en = 1'b1; push(w, 1'b1);
    w = '0;
    case (op)
      OP_R, OP_I: begin
        w.alu_src_a = 1'b1; w.alu_op = 2'd2; w.aluout_en = 1'b1;
        w.alu_src_b = (op == OP_I) ? 2'd2 : 2'd0;
        push(w, 1'b1);
        w = '0; w.rf_we = 1'b1; push(w, 1'b1);
      end
      OP_LOAD, OP_STORE: begin
        w.alu_src_a = 1'b1; w.alu_src_b = 2'd2; w.aluout_en = 1'b1;
        push(w, 1'b1);
        w = '0; w.addr_sel = 1'b1;
        if (op == OP_LOAD) w.mem_rd = 1'b1; else w.mem_wr = 1'b1;
        d = w;
        if (op == OP_LOAD) d.mdr_en = 1'b1;
        mem_phase(w, d, mwait, tr);
        if (!tr && op == OP_LOAD) begin
          w = '0; w.rf_we = 1'b1; w.wb_sel = 2'd1; push(w, 1'b1);
        end
      end
      OP_BRANCH: begin
        w.alu_src_a = 1'b1; w.alu_op = 2'd1; w.pc_src = 2'd1;
        w.pc_en = ((f3 == 3'b000) && zero) || ((f3 == 3'b001) && !zero);
        push(w, 1'b1);
      end
      OP_JAL: begin
        w.rf_we = 1'b1; w.wb_sel = 2'd2; w.pc_en = 1'b1; w.pc_src = 2'd2;
        push(w, 1'b1);
      end
      OP_LUI: begin
        w.rf_we = 1'b1; w.wb_sel = 2'd3; push(w, 1'b1);
      end
      default: ;
    endcase
  endtask

  // Apply each queued cycle just after the rising edge, check at the falling edge
  task automatic run();
    vec_t v;
    while (q.size() > 0) begin
      v = q.pop_front();
      i_opcode = v.op; i_funct3 = v.f3; i_zero = v.zero; i_mem_rdy = v.rdy;
      #4;
      chk($sformatf("cycle%0d", cyc), 32'(cur()), 32'(v.exp));
      if (o_mem_rd && o_addr_sel) n_rd_alu++;
      if (o_mdr_en) n_mdr++;
      if (o_rf_we) n_rfwe++;
      cyc++;
      @(posedge i_clk); #1;
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    #1;
    chk("reset_outputs", 32'(cur()), 32'd0);
    chk("reset_state", 32'(o_state), 32'd0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    int base_rd, base_mdr, base_rf;
    @(posedge i_clk); #1;
    do_reset();

    // ADD with memory always ready
    instr(OP_R, 3'b000, 1'b0, 0, 0);
    chk("model_add_len", 32'(q.size()), 32'd4);
    chk("model_add_rfwe", {30'd0, q[2].exp.rf_we, q[3].exp.rf_we}, 32'd1);
    base_rf = n_rfwe;
    run();
    chk("add_rfwe_count", 32'(n_rfwe - base_rf), 32'd1);

    // LW with three wait cycles in the data read
    base_rd = n_rd_alu; base_mdr = n_mdr;
    instr(OP_LOAD, 3'b010, 1'b0, 1, 3);
    run();
    chk("lw_memrd_cycles", 32'(n_rd_alu - base_rd), 32'd4);
    chk("lw_mdr_pulses", 32'(n_mdr - base_mdr), 32'd1);

    instr(OP_STORE, 3'b010, 1'b0, 0, 2);
    instr(OP_I, 3'b000, 1'b0, 2, 0);
    instr(OP_BRANCH, 3'b000, 1'b1, 0, 0);
    instr(OP_BRANCH, 3'b000, 1'b0, 0, 0);
    instr(OP_BRANCH, 3'b001, 1'b0, 0, 0);
    instr(OP_BRANCH, 3'b001, 1'b1, 0, 0);
    instr(OP_BRANCH, 3'b100, 1'b1, 0, 0);
    instr(OP_JAL, 3'b000, 1'b0, 0, 0);
    instr(OP_LUI, 3'b000, 1'b0, 1, 0);
    run();

    // Reset in the middle of a data read
    instr(OP_LOAD, 3'b010, 1'b0, 1, 10);
    while (q.size() > 7) void'(q.pop_back());
    run();
    chk("mid_read_memrd", 32'(o_mem_rd), 32'd1);
    do_reset();

    // Illegal opcode: trap is absorbing and ignores MEM_RDY
    instr(OP_BAD, 3'b000, 1'b0, 0, 0);
    trap_cycles(20);
    run();
    chk("bad_op_err", 32'(o_err), 32'd1);
    do_reset();

    // Fetch timeout after MEM_TIMEOUT+1 not-ready cycles
    instr(OP_R, 3'b000, 1'b0, 16, 0);
    chk("model_timeout_len", 32'(q.size()), 32'd16);
    trap_cycles(3);
    run();
    do_reset();

    // Ready on the last allowed cycle completes normally
    instr(OP_R, 3'b000, 1'b0, 15, 0);
    run();

    // Store timeout
    instr(OP_STORE, 3'b010, 1'b0, 0, 20);
    trap_cycles(2);
    run();
    chk("store_timeout_err", 32'(o_err), 32'd1);
    do_reset();
    instr(OP_LUI, 3'b000, 1'b0, 0, 0);
    run();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
